// File: rtl/step_counter_pkg.sv
// Shared types and defaults for the step counter: FSM state encoding,
// counter operation codes and a load clamp helper.
package step_counter_pkg;

  localparam int DEF_WIDTH   = 2;
  localparam int DEF_MODULUS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // Operation the control block requests from the count register each edge.
  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_CLR  = 2'b01,
    OP_INC  = 2'b10,
    OP_LOAD = 2'b11
  } cnt_op_e;

  function automatic logic [15:0] clamp16(input logic [15:0] val, input logic [15:0] lim);
    return (val > lim) ? lim : val;
  endfunction

endpackage

// File: rtl/step_counter_ctrl.sv
// Control for the step counter: sclr/load/count priority, ONE_SHOT sweep FSM,
// registered done/busy. STEP_COUNTER_SATURATE_EN selects hold-at-max counting.
module step_counter_ctrl
  import step_counter_pkg::*;
#(
  parameter int ONE_SHOT = 0
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    sclr_i,
  input  logic    load_i,
  input  logic    en_i,
  input  logic    start_i,
  input  logic    at_max_i,
`ifdef STEP_COUNTER_SATURATE_EN
  input  logic    at_pre_i,
`endif
  output cnt_op_e op_o,
  output logic    done_o,
  output logic    busy_o,
  output state_e  state_o
);

  state_e state_q, state_d;
  logic   done_q, done_d;
  logic   busy_q, busy_d;
  logic   wrap_done;

  always_comb begin
    state_d   = state_q;
    op_o      = OP_HOLD;
    wrap_done = 1'b0;
    if (sclr_i) begin
      state_d = IDLE;
      op_o    = OP_CLR;
    end else if (load_i) begin
      // Load keeps the FSM where it is; DONE still lasts only one cycle.
      op_o = OP_LOAD;
      if (state_q == DONE) state_d = IDLE;
    end else if (ONE_SHOT == 0) begin
      state_d = IDLE;
      if (en_i) begin
`ifdef STEP_COUNTER_SATURATE_EN
        if (!at_max_i) begin
          op_o      = OP_INC;
          wrap_done = at_pre_i;
        end
`else
        if (at_max_i) begin
          op_o      = OP_CLR;
          wrap_done = 1'b1;
        end else begin
          op_o = OP_INC;
        end
`endif
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_d = RUN;
            op_o    = OP_CLR;
          end
        end
        RUN: begin
          if (en_i) begin
            if (at_max_i) begin
              state_d = DONE;
              op_o    = OP_CLR;
            end else begin
              op_o = OP_INC;
            end
          end
        end
        DONE: begin
          if (start_i) begin
            state_d = RUN;
            op_o    = OP_CLR;
          end else begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          op_o    = OP_CLR;
        end
      endcase
    end
    done_d = (ONE_SHOT != 0) ? (state_d == DONE) : wrap_done;
    busy_d = (ONE_SHOT != 0) && (state_d == RUN);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign done_o  = done_q;
  assign busy_o  = busy_q;
  assign state_o = state_q;

endmodule

// File: rtl/step_counter.sv
// Modulo step counter with sync clear/load, free-running or one-shot sweep.
// Define STEP_COUNTER_SATURATE_EN to hold at MODULUS-1 in free-running mode.
module step_counter
  import step_counter_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int MODULUS  = DEF_MODULUS,
  parameter int ONE_SHOT = 0
) (
  input  logic             clk,
  input  logic             aclr_n,
  input  logic             sclr,
  input  logic             en,
  input  logic             start,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count_out,
  output logic             tc,
  output logic             done,
  output logic             busy,
  output logic [1:0]       dbg_state_o
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] load_clamped;
  logic             at_max;
  cnt_op_e          op;
  state_e           ctrl_state;

  assign at_max       = (count_q == MAX_VAL);
  assign load_clamped = WIDTH'(clamp16(16'(load_val), 16'(MODULUS - 1)));

`ifdef STEP_COUNTER_SATURATE_EN
  localparam logic [WIDTH-1:0] PRE_VAL = WIDTH'(MODULUS - 2);
  logic at_pre;
  assign at_pre = (count_q == PRE_VAL);
`endif

  step_counter_ctrl #(
    .ONE_SHOT (ONE_SHOT)
  ) u_ctrl (
    .clk_i    (clk),
    .rst_ni   (aclr_n),
    .sclr_i   (sclr),
    .load_i   (load),
    .en_i     (en),
    .start_i  (start),
    .at_max_i (at_max),
`ifdef STEP_COUNTER_SATURATE_EN
    .at_pre_i (at_pre),
`endif
    .op_o     (op),
    .done_o   (done),
    .busy_o   (busy),
    .state_o  (ctrl_state)
  );

  always_comb begin
    count_d = count_q;
    case (op)
      OP_CLR:  count_d = '0;
      OP_INC:  count_d = count_q + WIDTH'(1);
      OP_LOAD: count_d = load_clamped;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_out   = count_q;
  assign tc          = at_max;
  assign dbg_state_o = ctrl_state;

endmodule

// File: tb/tb_step_counter.sv
// Bench for step_counter: a default free-running instance (u_a) and a
// WIDTH=4 / MODULUS=10 one-shot instance (u_b), checked through expected queues.
module tb_step_counter;

  logic       clk = 1'b0;
  logic       rst_a_n, a_sclr, a_en, a_start, a_load;
  logic [1:0] a_lv, a_cnt, a_state;
  logic       a_tc, a_done, a_busy;
  logic       rst_b_n, b_sclr, b_en, b_start, b_load;
  logic [3:0] b_lv, b_cnt;
  logic [1:0] b_state;
  logic       b_tc, b_done, b_busy;

  int n_checks = 0;
  int n_fail   = 0;
  int a_idx    = 0;
  int b_idx    = 0;

  // Expected {count[3:0], tc, done, busy} per checked edge.
  logic [6:0] exp_a_q[$];
  logic [6:0] exp_b_q[$];

  always #5 clk = ~clk;

  step_counter u_a (
    .clk(clk), .aclr_n(rst_a_n), .sclr(a_sclr), .en(a_en), .start(a_start),
    .load(a_load), .load_val(a_lv), .count_out(a_cnt), .tc(a_tc),
    .done(a_done), .busy(a_busy), .dbg_state_o(a_state)
  );

  step_counter #(.WIDTH(4), .MODULUS(10), .ONE_SHOT(1)) u_b (
    .clk(clk), .aclr_n(rst_b_n), .sclr(b_sclr), .en(b_en), .start(b_start),
    .load(b_load), .load_val(b_lv), .count_out(b_cnt), .tc(b_tc),
    .done(b_done), .busy(b_busy), .dbg_state_o(b_state)
  );

  // Default instance, en=1 for 9 clocks from count 0.
`ifdef STEP_COUNTER_SATURATE_EN
  localparam int A1_CNT  [9] = '{1, 2, 3, 3, 3, 3, 3, 3, 3};
  localparam int A1_TC   [9] = '{0, 0, 1, 1, 1, 1, 1, 1, 1};
  localparam int A1_DONE [9] = '{0, 0, 1, 0, 0, 0, 0, 0, 0};
`else
  localparam int A1_CNT  [9] = '{1, 2, 3, 0, 1, 2, 3, 0, 1};
  localparam int A1_TC   [9] = '{0, 0, 1, 0, 0, 0, 1, 0, 0};
  localparam int A1_DONE [9] = '{0, 0, 0, 1, 0, 0, 0, 1, 0};
`endif

  // One-shot sweep, en=1; entry 0 is the start edge, done on the 11th edge.
  localparam int B1_CNT  [13] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 0, 0};
  localparam int B1_TC   [13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
  localparam int B1_DONE [13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
  localparam int B1_BUSY [13] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0};

  function automatic logic [6:0] pk(input int c, input int t, input int d, input int b);
    return {c[3:0], t[0], d[0], b[0]};
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic step_a(input int sclr, input int load, input int lv, input int en,
                        input int start, input logic [6:0] exp);
    @(negedge clk);
    a_sclr = sclr[0]; a_load = load[0]; a_lv = lv[1:0]; a_en = en[0]; a_start = start[0];
    exp_a_q.push_back(exp);
  endtask

  task automatic step_b(input int sclr, input int load, input int lv, input int en,
                        input int start, input logic [6:0] exp);
    @(negedge clk);
    b_sclr = sclr[0]; b_load = load[0]; b_lv = lv[3:0]; b_en = en[0]; b_start = start[0];
    exp_b_q.push_back(exp);
  endtask

  initial begin : monitor
    logic [6:0] e;
    logic [6:0] act;
    forever begin
      @(posedge clk);
      #1;
      if (exp_a_q.size() != 0) begin
        e   = exp_a_q.pop_front();
        act = {2'b00, a_cnt, a_tc, a_done, a_busy};
        n_checks++;
        if (act !== e) begin
          n_fail++;
          $display("FAIL a_out[%0d]: got cnt=%0d tc=%0b done=%0b busy=%0b, expected cnt=%0d tc=%0b done=%0b busy=%0b",
                   a_idx, act[6:3], act[2], act[1], act[0], e[6:3], e[2], e[1], e[0]);
        end
        a_idx++;
      end
      if (exp_b_q.size() != 0) begin
        e   = exp_b_q.pop_front();
        act = {b_cnt, b_tc, b_done, b_busy};
        n_checks++;
        if (act !== e) begin
          n_fail++;
          $display("FAIL b_out[%0d]: got cnt=%0d tc=%0b done=%0b busy=%0b, expected cnt=%0d tc=%0b done=%0b busy=%0b",
                   b_idx, act[6:3], act[2], act[1], act[0], e[6:3], e[2], e[1], e[0]);
        end
        b_idx++;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: bench did not reach its end, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rst_a_n = 1'b0; a_sclr = 1'b0; a_en = 1'b0; a_start = 1'b0; a_load = 1'b0; a_lv = 2'd0;
    rst_b_n = 1'b0; b_sclr = 1'b0; b_en = 1'b0; b_start = 1'b0; b_load = 1'b0; b_lv = 4'd0;
    #12;
    check("a_reset", {2'b00, a_cnt, a_tc, a_done, a_busy}, 7'd0);
    check("b_reset", {b_cnt, b_tc, b_done, b_busy}, 7'd0);
    @(negedge clk);
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;

    // Free-running counting; start toggles and must be ignored.
    for (int i = 0; i < 9; i++)
      step_a(0, 0, 0, 1, i % 2, pk(A1_CNT[i], A1_TC[i], A1_DONE[i], 0));
    step_a(1, 1, 2, 1, 0, pk(0, 0, 0, 0));   // sclr beats load
    step_a(0, 1, 3, 1, 0, pk(3, 1, 0, 0));   // load beats count
    step_a(0, 0, 0, 0, 0, pk(3, 1, 0, 0));   // en=0 holds
`ifdef STEP_COUNTER_SATURATE_EN
    step_a(0, 0, 0, 1, 0, pk(3, 1, 0, 0));
`else
    step_a(0, 0, 0, 1, 0, pk(0, 0, 1, 0));
`endif
    step_a(1, 0, 0, 1, 0, pk(0, 0, 0, 0));
    step_a(0, 0, 0, 1, 0, pk(1, 0, 0, 0));

    // Full one-shot sweep; second start pulse lands in RUN and is ignored.
    for (int i = 0; i < 13; i++)
      step_b(0, 0, 0, 1, (i == 0 || i == 4) ? 1 : 0,
             pk(B1_CNT[i], B1_TC[i], B1_DONE[i], B1_BUSY[i]));

    // Load clamps to MODULUS-1; sclr wins over load; load inside a sweep.
    step_b(0, 1, 13, 1, 0, pk(9, 1, 0, 0));
    step_b(1, 1, 5, 1, 0, pk(0, 0, 0, 0));
    step_b(0, 0, 0, 1, 1, pk(0, 0, 0, 1));
    step_b(0, 0, 0, 1, 0, pk(1, 0, 0, 1));
    step_b(0, 1, 7, 1, 0, pk(7, 0, 0, 1));
    step_b(0, 0, 0, 1, 0, pk(8, 0, 0, 1));
    step_b(0, 0, 0, 1, 0, pk(9, 1, 0, 1));
    step_b(0, 0, 0, 1, 0, pk(0, 0, 1, 0));
    step_b(0, 0, 0, 1, 0, pk(0, 0, 0, 0));

    // en alternating 0/1: counts only on en=1 edges.
    step_b(0, 0, 0, 1, 1, pk(0, 0, 0, 1));
    for (int k = 0; k < 10; k++) begin
      step_b(0, 0, 0, 0, 0, pk(k, (k == 9) ? 1 : 0, 0, 1));
      if (k < 9) step_b(0, 0, 0, 1, 0, pk(k + 1, (k == 8) ? 1 : 0, 0, 1));
      else       step_b(0, 0, 0, 1, 0, pk(0, 0, 1, 0));
    end
    step_b(0, 0, 0, 0, 1, pk(0, 0, 0, 1));   // DONE with start restarts
    step_b(0, 0, 0, 0, 0, pk(0, 0, 0, 1));
    step_b(1, 0, 0, 0, 0, pk(0, 0, 0, 0));

    // Asynchronous reset at count 5 aborts the sweep.
    step_b(0, 0, 0, 1, 1, pk(0, 0, 0, 1));
    for (int k = 1; k <= 5; k++) step_b(0, 0, 0, 1, 0, pk(k, 0, 0, 1));
    @(posedge clk);
    #3 rst_b_n = 1'b0;
    #1;
    check("b_async_rst", {b_cnt, b_tc, b_done, b_busy}, 7'd0);
    check("b_async_rst_state", {5'b0, b_state}, 7'd0);
    repeat (2) @(negedge clk);
    check("b_rst_held", {b_cnt, b_tc, b_done, b_busy}, 7'd0);
    rst_b_n = 1'b1;
    for (int k = 0; k < 12; k++) step_b(0, 0, 0, 1, 0, pk(0, 0, 0, 0));
    @(posedge clk);
    #2;
    check("b_idle_after_rst", {5'b0, b_state}, 7'd0);
    step_b(0, 0, 0, 1, 1, pk(0, 0, 0, 1));

    for (int i = 0; i < 10 && (exp_a_q.size() != 0 || exp_b_q.size() != 0); i++)
      @(posedge clk);
    #2;
    n_checks++;
    if (exp_a_q.size() != 0 || exp_b_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d/%0d expected entries left, required 0/0",
               exp_a_q.size(), exp_b_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
